// File: rtl/bus_router.sv
// bus_router: shared registered bus; round-robin arbitration of NSRC sources into one holding
// register that delivers to one of NDST destinations, valid/ready on both sides.
module bus_router #(
  parameter int WIDTH = 8,
  parameter int NSRC = 2,
  parameter int NDST = 2,
  localparam int DSTW = (NDST > 1) ? $clog2(NDST) : 1,
  localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC*DSTW-1:0]    src_dest,
  output logic [NSRC-1:0]         src_ready,
  output logic [NDST-1:0]         dst_valid,
  output logic [NDST*WIDTH-1:0]   dst_data,
  input  logic [NDST-1:0]         dst_ready,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic                    drop_err
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_bus_data;
  logic [DSTW-1:0] r_bus_dest, w_dest;
  logic [GW-1:0] r_rr_ptr, r_grant_id, w_win, w_idx;
  logic r_drop_err, w_found, w_drain, w_can, w_acc, w_oor;
  assign busy = (r_state == FULL);
  // dst_ready reaches src_ready combinationally through w_drain; budget that path in timing.
  assign w_drain = busy & dst_ready[r_bus_dest];
  assign w_can = ~busy | w_drain;
  // Descending offset scan so the source closest to r_rr_ptr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % NSRC);
      if (src_valid[w_idx]) begin
        w_found = 1'b1;
        w_win = w_idx;
      end
    end
  end
  assign w_acc = w_can & w_found;
  assign src_ready = w_acc ? (NSRC'(1) << w_win) : '0;
  assign w_dest = src_dest[w_win*DSTW +: DSTW];
  assign w_oor = int'(w_dest) >= NDST;
  always_comb w_next = (w_acc & ~w_oor) ? FULL : w_drain ? EMPTY : r_state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_bus_data <= '0;
      r_bus_dest <= '0;
      r_rr_ptr <= '0;
      r_grant_id <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_rr_ptr <= (int'(w_win) == NSRC - 1) ? '0 : w_win + GW'(1);
        r_grant_id <= w_win;
        if (w_oor) r_drop_err <= 1'b1;
        else begin
          r_bus_data <= src_data[w_win*WIDTH +: WIDTH];
          r_bus_dest <= w_dest;
        end
      end
    end
  end
  always_comb begin
    dst_valid = '0;
    dst_data = '0;
    if (busy) begin
      dst_valid[r_bus_dest] = 1'b1;
      dst_data[r_bus_dest*WIDTH +: WIDTH] = r_bus_data;
    end
  end
  assign grant_id = r_grant_id;
  assign drop_err = r_drop_err;
endmodule
